// File: rtl/ldst_sched_pkg.sv
// Shared types and helpers for the load/store pipe owner scheduler.
package ldst_sched_pkg;

    typedef enum logic [1:0] {
        S_EXE          = 2'd0,
        S_DRAIN_TO_EXC = 2'd1,
        S_EXC          = 2'd2,
        S_DRAIN_TO_EXE = 2'd3
    } ldst_sched_state_t;

    localparam logic LDST_OWNER_EXE    = 1'b0;
    localparam logic LDST_OWNER_EXCEPT = 1'b1;

    function automatic int cnt_width(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

    // The pipe stays with the current owner until its drain completes.
    function automatic logic state_owner(input ldst_sched_state_t s);
        return ((s == S_EXC) || (s == S_DRAIN_TO_EXE)) ? LDST_OWNER_EXCEPT : LDST_OWNER_EXE;
    endfunction

endpackage

// File: rtl/ldst_sched_outstanding_cnt.sv
// Saturating up/down count of accepted-but-unanswered pipe transactions.
module ldst_sched_outstanding_cnt
    import ldst_sched_pkg::*;
#(
    parameter int P_MAX = 4,
    parameter int CW    = cnt_width(P_MAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          zero,
    output logic          next_zero,
    output logic          underflow
);

    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(P_MAX);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        full  = (count_q == CNT_MAX);
        zero  = (count_q == '0);
        count_d = count_q;
        // Simultaneous increment and decrement cancel; both ends hold rather than wrap.
        if (inc && !dec && !full) begin
            count_d = count_q + CNT_ONE;
        end else if (dec && !inc && !zero) begin
            count_d = count_q - CNT_ONE;
        end
        next_zero = (count_d == '0);
        underflow = dec && zero;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ldst_pipe_scheduler.sv
// Owner controller for the shared load/store pipe: drains outstanding
// transactions before handing the pipe between EXE and the exception handler.
module ldst_pipe_scheduler
    import ldst_sched_pkg::*;
#(
    parameter int P_MAX_OUTSTANDING = 4,
    parameter int P_DRAIN_TIMEOUT   = 256
) (
    input  logic       iCLOCK,
    input  logic       iRESET_SYNC,
    input  logic       iEXCEPT_ACTIVE,
    input  logic       iEXE_REQ,
    output logic       oEXE_BUSY,
    output logic       oEXE_REQ,
    input  logic       iEXCEPT_REQ,
    output logic       oEXCEPT_BUSY,
    output logic       oEXCEPT_REQ,
    output logic       oLDST_REQ,
    input  logic       iLDST_BUSY,
    input  logic       iLDST_VALID,
    output logic       oUSE_SEL,
    output logic [3:0] oOUTSTANDING,
    output logic       oDRAIN_TIMEOUT,
    output logic       oPROTO_ERR
);

    localparam int CW = cnt_width(P_MAX_OUTSTANDING);
    localparam int TW = $clog2(P_DRAIN_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_MAX  = TW'(P_DRAIN_TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(P_DRAIN_TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    ldst_sched_state_t state_q, state_d;
    logic              use_sel_q, use_sel_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              timeout_q, timeout_d;
    logic              proto_err_q, proto_err_d;

    logic [CW-1:0] cnt_value;
    logic          cnt_full, cnt_zero, cnt_next_zero, cnt_underflow;
    logic          in_exe, in_exc, in_drain, owner;
    logic          exe_busy, exc_busy, ldst_req, accept;

    ldst_sched_outstanding_cnt #(
        .P_MAX (P_MAX_OUTSTANDING),
        .CW    (CW)
    ) u_outstanding_cnt (
        .clk       (iCLOCK),
        .rst       (iRESET_SYNC),
        .inc       (accept),
        .dec       (iLDST_VALID),
        .count     (cnt_value),
        .full      (cnt_full),
        .zero      (cnt_zero),
        .next_zero (cnt_next_zero),
        .underflow (cnt_underflow)
    );

    // Handshake: a requester may issue only in a cycle where its BUSY is low;
    // the pipe takes oLDST_REQ when iLDST_BUSY is low, and answers each taken
    // request with exactly one iLDST_VALID pulse, routed to the current owner.
    always_comb begin
        in_exe   = (state_q == S_EXE);
        in_exc   = (state_q == S_EXC);
        in_drain = (state_q == S_DRAIN_TO_EXC) || (state_q == S_DRAIN_TO_EXE);
        owner    = state_owner(state_q);
        // ACTIVE blocks EXE in the very cycle it is first seen.
        exe_busy = !in_exe || iLDST_BUSY || cnt_full || iEXCEPT_ACTIVE;
        exc_busy = !in_exc || iLDST_BUSY || cnt_full;
        ldst_req = (in_exe && iEXE_REQ && !exe_busy) || (in_exc && iEXCEPT_REQ && !exc_busy);
        accept   = ldst_req && !iLDST_BUSY;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_EXE: begin
                if (iEXCEPT_ACTIVE) begin
                    state_d = cnt_zero ? S_EXC : S_DRAIN_TO_EXC;
                end
            end
            S_DRAIN_TO_EXC: begin
                if (cnt_next_zero) begin
                    state_d = S_EXC;
                end
            end
            S_EXC: begin
                if (!iEXCEPT_ACTIVE) begin
                    state_d = cnt_next_zero ? S_EXE : S_DRAIN_TO_EXE;
                end
            end
            S_DRAIN_TO_EXE: begin
                if (cnt_next_zero) begin
                    state_d = S_EXE;
                end
            end
            default: state_d = S_EXE;
        endcase

        use_sel_d = state_owner(state_d);

        // Timer reads zero on the first drain cycle and counts completed drain cycles.
        timer_d = '0;
        if (in_drain) begin
            timer_d = (timer_q == TIMER_MAX) ? timer_q : timer_q + TIMER_ONE;
        end
        timeout_d   = timeout_q || (in_drain && (timer_q >= TIMER_LAST));
        proto_err_d = proto_err_q || cnt_underflow
                      || (iEXE_REQ && exe_busy) || (iEXCEPT_REQ && exc_busy);
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state_q     <= S_EXE;
            use_sel_q   <= LDST_OWNER_EXE;
            timer_q     <= '0;
            timeout_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            use_sel_q   <= use_sel_d;
            timer_q     <= timer_d;
            timeout_q   <= timeout_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        oOUTSTANDING           = '0;
        oOUTSTANDING[CW-1:0]   = cnt_value;
    end

    assign oEXE_BUSY      = exe_busy;
    assign oEXCEPT_BUSY   = exc_busy;
    assign oLDST_REQ      = ldst_req;
    assign oEXE_REQ       = iLDST_VALID && (owner == LDST_OWNER_EXE);
    assign oEXCEPT_REQ    = iLDST_VALID && (owner == LDST_OWNER_EXCEPT);
    assign oUSE_SEL       = use_sel_q;
    assign oDRAIN_TIMEOUT = timeout_q;
    assign oPROTO_ERR     = proto_err_q;

endmodule

// File: tb/tb_ldst_pipe_scheduler.sv
// Bench for ldst_pipe_scheduler: directed scenarios plus random traffic
// against an owner/switching/count reference model.
module tb_ldst_pipe_scheduler;

    localparam int MAXO = 4;
    localparam int TMO  = 256;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       active = 1'b0, exe_req = 1'b0, exc_req = 1'b0;
    logic       ldst_busy = 1'b0, ldst_valid = 1'b0;
    logic       exe_busy_o, exe_resp_o, exc_busy_o, exc_resp_o, ldst_req_o, use_sel_o;
    logic [3:0] outstanding_o;
    logic       timeout_o, proto_err_o;

    always #5 clk = ~clk;

    ldst_pipe_scheduler #(
        .P_MAX_OUTSTANDING (MAXO),
        .P_DRAIN_TIMEOUT   (TMO)
    ) dut (
        .iCLOCK         (clk),
        .iRESET_SYNC    (rst),
        .iEXCEPT_ACTIVE (active),
        .iEXE_REQ       (exe_req),
        .oEXE_BUSY      (exe_busy_o),
        .oEXE_REQ       (exe_resp_o),
        .iEXCEPT_REQ    (exc_req),
        .oEXCEPT_BUSY   (exc_busy_o),
        .oEXCEPT_REQ    (exc_resp_o),
        .oLDST_REQ      (ldst_req_o),
        .iLDST_BUSY     (ldst_busy),
        .iLDST_VALID    (ldst_valid),
        .oUSE_SEL       (use_sel_o),
        .oOUTSTANDING   (outstanding_o),
        .oDRAIN_TIMEOUT (timeout_o),
        .oPROTO_ERR     (proto_err_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who owns the pipe, whether a hand-over is pending,
    // how many transactions are in flight, and the sticky flags.
    int m_owner, m_switching, m_count, m_drain_cycles, m_timeout, m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit may_exe(input bit act, input bit busy);
        return (m_switching == 0) && (m_owner == 0) && !busy && (m_count < MAXO) && !act;
    endfunction

    function automatic bit may_exc(input bit busy);
        return (m_switching == 0) && (m_owner == 1) && !busy && (m_count < MAXO);
    endfunction

    task automatic model_reset();
        m_owner = 0; m_switching = 0; m_count = 0;
        m_drain_cycles = 0; m_timeout = 0; m_err = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; active = 0; exe_req = 0; exc_req = 0; ldst_busy = 0; ldst_valid = 0;
        @(posedge clk);
        model_reset();
    endtask

    task automatic step(input bit a, input bit er, input bit xr, input bit b, input bit v);
        bit me, mx, acc;
        int nc;
        @(negedge clk);
        rst = 1'b0; active = a; exe_req = er; exc_req = xr; ldst_busy = b; ldst_valid = v;
        #1;
        me  = may_exe(a, b);
        mx  = may_exc(b);
        acc = (er && me) || (xr && mx);
        check("ldst_req",    ldst_req_o,    acc);
        check("exe_busy",    exe_busy_o,    !me);
        check("exc_busy",    exc_busy_o,    !mx);
        check("exe_resp",    exe_resp_o,    v && (m_owner == 0));
        check("exc_resp",    exc_resp_o,    v && (m_owner == 1));
        check("use_sel",     use_sel_o,     m_owner);
        check("outstanding", outstanding_o, m_count);
        check("timeout",     timeout_o,     m_timeout);
        check("proto_err",   proto_err_o,   m_err);
        @(posedge clk);
        if ((v && m_count == 0) || (er && !me) || (xr && !mx)) m_err = 1;
        nc = m_count;
        if (acc && !v) nc = m_count + 1;
        else if (v && !acc && m_count > 0) nc = m_count - 1;
        if (m_switching != 0) begin
            m_drain_cycles++;
            if (m_drain_cycles >= TMO) m_timeout = 1;
        end else begin
            m_drain_cycles = 0;
        end
        if (m_switching == 0 && m_owner == 0 && a) begin
            if (m_count == 0) m_owner = 1;
            else m_switching = 1;
        end else if (m_switching == 0 && m_owner == 1 && !a) begin
            if (nc == 0) m_owner = 0;
            else m_switching = 1;
        end else if (m_switching != 0 && nc == 0) begin
            m_owner = 1 - m_owner;
            m_switching = 0;
        end
        m_count = nc;
    endtask

    task automatic random_traffic(input int cycles, input bit allow_violations);
        bit a, b, er, xr, v;
        a = 0;
        for (int i = 0; i < cycles; i++) begin
            if ($urandom_range(0, 24) == 0) a = ~a;
            b = ($urandom_range(0, 4) == 0);
            if (allow_violations) begin
                er = ($urandom_range(0, 3) == 0);
                xr = ($urandom_range(0, 3) == 0);
                v  = ($urandom_range(0, 3) == 0);
            end else begin
                er = $urandom_range(0, 1) && may_exe(a, b);
                xr = $urandom_range(0, 1) && may_exc(b);
                v  = (m_count > 0) && ($urandom_range(0, 2) == 0);
            end
            step(a, er, xr, b, v);
        end
    endtask

    initial begin
        model_reset();
        do_reset();
        step(0, 0, 0, 0, 0);

        // Three EXE transactions then their responses.
        repeat (3) step(0, 1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // Hand-over to EXCEPT with two in flight.
        repeat (2) step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        repeat (2) step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);

        // EXCEPT issues one, then releases with it still outstanding.
        step(1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // Fill to the limit, then accept and respond together at count 3.
        repeat (4) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0, 1);
        step(0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // Drain that never gets a response until past the timeout.
        step(0, 1, 0, 0, 0);
        repeat (TMO + 3) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        repeat (2) step(1, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0);

        do_reset();
        random_traffic(2000, 0);

        // Response with nothing outstanding.
        random_traffic(0, 0);
        while (m_count > 0) step(m_owner == 1 && m_switching == 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        do_reset();
        random_traffic(500, 1);

        // Reset in the middle of a drain, then a stray late response.
        do_reset();
        repeat (2) step(0, 1, 0, 0, 0);
        repeat (2) step(1, 0, 0, 0, 0);
        do_reset();
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ldst_pipe_scheduler.md
Name: ldst_pipe_scheduler

Overview:
Dynamic owner controller for the shared load/store pipe. It generates the requester-select bit that steers the existing EXE/EXCEPT load/store mux, replacing the static select. It tracks outstanding pipe transactions and drains them before handing the pipe between the execution unit and the exception handler. It sits between both requesters and the load/store pipe and handles control handshakes only; payload muxing stays in the existing arbiter.

Parameters:
P_MAX_OUTSTANDING, 4, maximum accepted-but-unanswered pipe transactions (1..15).
P_DRAIN_TIMEOUT, 256, drain-state cycle count that sets the timeout flag (>=1).

Ports:
iCLOCK  in  1  clock; all state updates on the rising edge.
iRESET_SYNC  in  1  synchronous reset, active high.
iEXCEPT_ACTIVE  in  1  level; exception handler requests pipe ownership.
iEXE_REQ  in  1  EXE issues a transaction; valid only when oEXE_BUSY=0.
oEXE_BUSY  out  1  EXE must not issue.
oEXE_REQ  out  1  response valid toward EXE.
iEXCEPT_REQ  in  1  EXCEPT issues a transaction; valid only when oEXCEPT_BUSY=0.
oEXCEPT_BUSY  out  1  EXCEPT must not issue.
oEXCEPT_REQ  out  1  response valid toward EXCEPT.
oLDST_REQ  out  1  request to the pipe.
iLDST_BUSY  in  1  pipe cannot accept.
iLDST_VALID  in  1  pipe response valid, one per accepted request.
oUSE_SEL  out  1  registered owner select (0=EXE, 1=EXCEPT) to the payload mux.
oOUTSTANDING  out  4  current outstanding count.
oDRAIN_TIMEOUT  out  1  sticky; drain exceeded P_DRAIN_TIMEOUT.
oPROTO_ERR  out  1  sticky; response with count 0, or request while busy.

Behaviour:
- States: S_EXE, S_DRAIN_TO_EXC, S_EXC, S_DRAIN_TO_EXE. Reset state is S_EXE.
- Reset values: count=0, oUSE_SEL=0, drain timer=0, both sticky flags=0. Outputs at reset: oEXE_BUSY=iLDST_BUSY|iEXCEPT_ACTIVE, oEXCEPT_BUSY=1, oLDST_REQ=0 unless EXE issues.
- owner = 0 in S_EXE and S_DRAIN_TO_EXC; owner = 1 otherwise. oUSE_SEL is a flop equal to owner.
- full = (count == P_MAX_OUTSTANDING).
- oEXE_BUSY = !(state==S_EXE) | iLDST_BUSY | full | iEXCEPT_ACTIVE. EXE is blocked combinationally in the cycle ACTIVE is first seen.
- oEXCEPT_BUSY = !(state==S_EXC) | iLDST_BUSY | full.
- oLDST_REQ = (S_EXE & iEXE_REQ & !oEXE_BUSY) | (S_EXC & iEXCEPT_REQ & !oEXCEPT_BUSY). Combinational, 0-cycle latency.
- accept = oLDST_REQ & !iLDST_BUSY.
- Count: accept and no response gives +1. Response and no accept gives -1. Both or neither gives no change. It never wraps.
- Response routing: oEXE_REQ = iLDST_VALID & owner==0; oEXCEPT_REQ = iLDST_VALID & owner==1. Same cycle, no latency.
- iLDST_VALID with count==0: still routed, count stays 0, oPROTO_ERR set.
- iEXE_REQ with oEXE_BUSY=1, or iEXCEPT_REQ with oEXCEPT_BUSY=1: request ignored, oPROTO_ERR set.
- S_EXE transitions on iEXCEPT_ACTIVE: to S_EXC if count==0, else to S_DRAIN_TO_EXC.
- S_DRAIN_TO_EXC: go to S_EXC when next-count==0, i.e. count==1 with a response this cycle, or count==0. If ACTIVE drops during the drain, still complete to S_EXC. S_EXC then immediately returns via the S_EXC rule.
- S_EXC transitions when !iEXCEPT_ACTIVE: to S_EXE if next-count==0, else to S_DRAIN_TO_EXE. While ACTIVE stays high, remain in S_EXC.
- S_DRAIN_TO_EXE: go to S_EXE when next-count==0.
- Drain timer: clears on drain-state entry and increments each drain cycle, saturating. At P_DRAIN_TIMEOUT it sets oDRAIN_TIMEOUT; the FSM keeps waiting.
- Sticky flags clear only on reset.
- Reset asserted mid-drain or mid-transaction returns all state to reset values on the next edge. A late response then raises oPROTO_ERR.

Decomposition:
- Package ldst_sched_pkg holds:
  - state enum ldst_sched_state_t;
  - owner constants LDST_OWNER_EXE=1'b0 and LDST_OWNER_EXCEPT=1'b1;
  - count-width function clog2(P_MAX_OUTSTANDING+1).
- One sub-module, ldst_sched_outstanding_cnt: saturating up/down counter with full/zero/next-zero outputs and an underflow-error output.
- FSM, timer and flags live in the top module.

Test Plan:
- Reset, then EXE issues 3 requests with iLDST_BUSY=0 -> oLDST_REQ pulses 3 times, oOUTSTANDING=3. Three iLDST_VALID -> oEXE_REQ x3, count 0, oUSE_SEL=0.
- Count=2, raise iEXCEPT_ACTIVE -> oEXE_BUSY=1 that cycle, state S_DRAIN_TO_EXC, oUSE_SEL=0. After 2 responses (routed to EXE), oUSE_SEL=1 the next cycle and oEXCEPT_BUSY=0.
- iEXCEPT_ACTIVE with count=0 -> oUSE_SEL=1 one cycle later. Drop ACTIVE with count=1 -> S_DRAIN_TO_EXE; the response goes to oEXCEPT_REQ, then oUSE_SEL=0.
- Issue 4 with no responses -> oEXE_BUSY=1 from full. Simultaneous accept and response when count=4 is impossible; response plus new accept at count=3 -> count stays 3.
- Drain with no responses for 256 cycles -> oDRAIN_TIMEOUT=1 at cycle 256, state unchanged. A response then completes the switch, and the flag stays 1 until reset.
- iLDST_VALID at count 0 -> oPROTO_ERR=1. iRESET_SYNC pulse mid-drain -> next edge gives S_EXE, count 0, flags 0.
